dct4x4_ctrl: RTL

Sequencer for the 4-point HEVC DCT butterfly core that performs a full 4x4 2-D forward transform. It accepts four residual rows over a valid/ready stream and drives one externally instantiated core (WIDTH_X=16, WIDTH_Y=24) through a row pass, then a column pass. Between passes it rounds, shifts and saturates the intermediate results and holds them in a transpose buffer. It emits the 16 coefficients as four column beats on a valid/ready stream and sits between the residual generator and the quantizer.

---
 rtl/dct4x4_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dct4x4_ctrl.sv
// Sequencer for a 4x4 forward HEVC DCT built on one external 4-point butterfly core:
// row pass, rounded/saturated transpose buffer, column pass, then four column beats out.
module dct4x4_ctrl #(
  parameter int unsigned IN_W   = 9,
  parameter int unsigned SHIFT1 = 1,
  parameter int unsigned SHIFT2 = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic signed [IN_W-1:0] i_in_x0,
  input  logic signed [IN_W-1:0] i_in_x1,
  input  logic signed [IN_W-1:0] i_in_x2,
  input  logic signed [IN_W-1:0] i_in_x3,
  output logic signed [15:0]     o_core_x0,
  output logic signed [15:0]     o_core_x1,
  output logic signed [15:0]     o_core_x2,
  output logic signed [15:0]     o_core_x3,
  output logic                   o_core_load,
  input  logic signed [23:0]     i_core_y0,
  input  logic signed [23:0]     i_core_y1,
  input  logic signed [23:0]     i_core_y2,
  input  logic signed [23:0]     i_core_y3,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic signed [15:0]     o_out_c0,
  output logic signed [15:0]     o_out_c1,
  output logic signed [15:0]     o_out_c2,
  output logic signed [15:0]     o_out_c3,
  output logic                   o_busy
);

  typedef enum logic [2:0] {StRow, StWait1, StCol, StWait2, StOut} state_e;

  // Round-half-up, arithmetic shift and clamp; 25 bits so the rounding add cannot wrap.
  function automatic logic signed [15:0] round_sat(input logic signed [23:0] y,
                                                   input int unsigned sh);
    logic signed [24:0] v;
    v = (25'(y) + (25'sd1 <<< (sh - 1))) >>> sh;
    if (v > 25'sd32767) return 16'sh7fff;
    if (v < -25'sd32768) return 16'sh8000;
    return v[15:0];
  endfunction

  state_e             r_state;
  logic [1:0]         r_row_cnt, r_col_cnt, r_beat_cnt;
  logic               r_tag0_vld, r_tag0_col, r_tag1_vld, r_tag1_col;
  logic [1:0]         r_tag0_idx, r_tag1_idx;
  logic signed [15:0] r_t [4][4];  // [row][k]
  logic signed [15:0] r_c [4][4];  // [j][column]

  logic signed [IN_W-1:0] w_x [4];
  logic signed [23:0]     w_y [4];
  logic signed [15:0]     w_core_x [4];
  logic signed [15:0]     w_out_c [4];
  logic                   w_accept, w_cap_row3, w_cap_col3;

  always_comb begin
    w_x[0] = i_in_x0;
    w_x[1] = i_in_x1;
    w_x[2] = i_in_x2;
    w_x[3] = i_in_x3;
    w_y[0] = i_core_y0;
    w_y[1] = i_core_y1;
    w_y[2] = i_core_y2;
    w_y[3] = i_core_y3;
  end

  assign o_in_ready  = !rst && (r_state == StRow);
  assign w_accept    = o_in_ready && i_in_valid;
  assign o_core_load = w_accept || (!rst && (r_state == StCol));
  assign w_cap_row3  = r_tag1_vld && !r_tag1_col && (r_tag1_idx == 2'd3);
  assign w_cap_col3  = r_tag1_vld && r_tag1_col && (r_tag1_idx == 2'd3);
  assign o_out_valid = (r_state == StOut);
  assign o_busy      = !((r_state == StRow) && (r_row_cnt == 2'd0));

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_core_x[k] = '0;
      w_out_c[k]  = '0;
      if (!rst && (r_state == StRow)) begin
        w_core_x[k] = 16'(w_x[k]);
      end else if (!rst && (r_state == StCol)) begin
        w_core_x[k] = r_t[k][r_col_cnt];
      end
      if (r_state == StOut) begin
        w_out_c[k] = r_c[k][r_beat_cnt];
      end
    end
  end

  assign o_core_x0 = w_core_x[0];
  assign o_core_x1 = w_core_x[1];
  assign o_core_x2 = w_core_x[2];
  assign o_core_x3 = w_core_x[3];
  assign o_out_c0  = w_out_c[0];
  assign o_out_c1  = w_out_c[1];
  assign o_out_c2  = w_out_c[2];
  assign o_out_c3  = w_out_c[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StRow;
      r_row_cnt  <= 2'd0;
      r_col_cnt  <= 2'd0;
      r_beat_cnt <= 2'd0;
      r_tag0_vld <= 1'b0;
      r_tag0_col <= 1'b0;
      r_tag0_idx <= 2'd0;
      r_tag1_vld <= 1'b0;
      r_tag1_col <= 1'b0;
      r_tag1_idx <= 2'd0;
    end else begin
      // Tag pipeline mirrors the core's two-edge latency from load to capture.
      r_tag0_vld <= o_core_load;
      r_tag0_col <= (r_state == StCol);
      r_tag0_idx <= (r_state == StCol) ? r_col_cnt : r_row_cnt;
      r_tag1_vld <= r_tag0_vld;
      r_tag1_col <= r_tag0_col;
      r_tag1_idx <= r_tag0_idx;
      case (r_state)
        StRow: begin
          if (w_accept) begin
            r_row_cnt <= r_row_cnt + 2'd1;
            if (r_row_cnt == 2'd3) r_state <= StWait1;
          end
        end
        StWait1: if (w_cap_row3) r_state <= StCol;
        StCol: begin
          r_col_cnt <= r_col_cnt + 2'd1;
          if (r_col_cnt == 2'd3) r_state <= StWait2;
        end
        StWait2: if (w_cap_col3) r_state <= StOut;
        StOut: begin
          if (i_out_ready) begin
            r_beat_cnt <= r_beat_cnt + 2'd1;
            if (r_beat_cnt == 2'd3) r_state <= StRow;
          end
        end
        default: r_state <= StRow;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_tag1_vld) begin
      for (int k = 0; k < 4; k++) begin
        if (r_tag1_col) r_c[k][r_tag1_idx] <= round_sat(w_y[k], SHIFT2);
        else            r_t[r_tag1_idx][k] <= round_sat(w_y[k], SHIFT1);
      end
    end
  end

endmodule
